// File: rtl/cpu_loader_pkg.sv
// cpu_loader_pkg
// Shared types and address-map constants for the AHB CPU loader.
//   region_e  : decoded target of an AHB access (IM, DM, RF, CSR, error)
//   state_e   : bus-response FSM states
//   decode_region() : maps a byte address to a region. The CYCLE CSR
//                     only decodes when the caller enables it.
// Optional feature macro used by the top: CPU_LOADER_CYCLE_EN.
package cpu_loader_pkg;

    typedef enum logic [2:0] {R_IM, R_DM, R_RF, R_CSR, R_ERR} region_e;
    typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_ERR1, S_ERR2} state_e;

    localparam logic [15:0] IM_BASE  = 16'h0000;
    localparam logic [15:0] DM_BASE  = 16'h2000;
    localparam logic [15:0] RF_BASE  = 16'h4000;
    localparam logic [15:0] CSR_BASE = 16'h8000;

    // CSR word offsets within the CSR page (haddr[3:2])
    localparam logic [1:0] CSR_CTRL   = 2'd0;
    localparam logic [1:0] CSR_STATUS = 2'd1;
    localparam logic [1:0] CSR_CYCLE  = 2'd2;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    function automatic region_e decode_region(input logic [15:0] addr, input logic cycle_en);
        region_e r;
        r = R_ERR;
        // Only word-aligned addresses map to anything.
        if (addr[1:0] == 2'b00) begin
            if (addr[15:13] == IM_BASE[15:13]) begin
                r = R_IM;
            end else if (addr[15:13] == DM_BASE[15:13]) begin
                r = R_DM;
            end else if (addr[15:7] == RF_BASE[15:7]) begin
                r = R_RF;
            end else if (addr[15:4] == CSR_BASE[15:4]) begin
                if (addr[3:2] == CSR_CTRL || addr[3:2] == CSR_STATUS ||
                    (cycle_en && addr[3:2] == CSR_CYCLE)) begin
                    r = R_CSR;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ahb_cpu_loader_if.sv
// ahb_cpu_loader_if
// AHB-Lite bus signals between the host (master) and the CPU loader (slave).
//   master drives: hsel, haddr, htrans, hwrite, hsize, hwdata, hready
//   slave drives : hreadyout, hresp, hrdata
interface ahb_cpu_loader_if;
    logic        hsel;
    logic [15:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/cpu_cycle_counter.sv
// cpu_cycle_counter
// 32-bit free-running cycle counter with synchronous load.
//   clk, rst   : clock, synchronous active-high reset (count -> 0)
//   enable     : count up by one per cycle (wraps 0xFFFFFFFF -> 0)
//   load       : load load_value this cycle (takes priority over enable)
//   load_value : value to load
//   count      : current count
// Instantiated by ahb_cpu_loader only when CPU_LOADER_CYCLE_EN is defined.
module cpu_cycle_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        load,
    input  logic [31:0] load_value,
    output logic [31:0] count
);
    logic [31:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (enable) begin
            count_reg <= count_reg + 32'd1;
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/ahb_cpu_loader.sv
// ahb_cpu_loader
// AHB-Lite slave that lets a host load/read the CPU's instruction and data
// memories, read its register file, and control its run/hold reset.
//   clk, rst        : clock, synchronous active-high reset
//   bus             : AHB-Lite slave port (ahb_cpu_loader_if.slave)
//   cpu_rstn        : CPU reset (active low), equals CTRL.run
//   ahb_im_*        : IM debug port (addr/din/wen out, dout in, sync read)
//   ahb_dm_*        : DM debug port (addr/din/wen out, dout in, sync read)
//   ahb_rf_*        : RF debug read port (addr out, data in, sync read)
// Define CPU_LOADER_CYCLE_EN to add the CYCLE counter CSR at 0x8008;
// without it that address answers with ERROR.
module ahb_cpu_loader
    import cpu_loader_pkg::*;
#(
    parameter int MEM_AW  = 11,
    parameter int RF_AW   = 5,
    parameter bit RST_RUN = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    ahb_cpu_loader_if.slave   bus,
    output logic              cpu_rstn,
    output logic [MEM_AW-1:0] ahb_im_addr,
    output logic [31:0]       ahb_im_din,
    output logic              ahb_im_wen,
    input  logic [31:0]       ahb_im_dout,
    output logic [MEM_AW-1:0] ahb_dm_addr,
    output logic [31:0]       ahb_dm_din,
    output logic              ahb_dm_wen,
    input  logic [31:0]       ahb_dm_dout,
    output logic [RF_AW-1:0]  ahb_rf_addr,
    input  logic [31:0]       ahb_rf_data
);
`ifdef CPU_LOADER_CYCLE_EN
    localparam bit CYCLE_EN = 1'b1;
`else
    localparam bit CYCLE_EN = 1'b0;
`endif

    state_e            state_reg, state_next;
    region_e           region, rd_region_reg;
    logic              ready, accept, illegal, mem_write, run_eff;
    logic              run_reg, wr_blocked_reg;
    logic              im_wr_reg, dm_wr_reg, csr_wr_reg, csr_rd_reg, rd_done_reg;
    logic [1:0]        csr_off_reg;
    logic [MEM_AW-1:0] im_addr_reg, dm_addr_reg;
    logic [RF_AW-1:0]  rf_addr_reg;
    logic [31:0]       cycle_count;
    logic [31:0]       rdata;

    // The slave is ready in every state except the two stall cycles, so an
    // address phase can only land in IDLE or in the last cycle of an error.
    assign ready  = !(state_reg == S_RD_WAIT || state_reg == S_ERR1);
    assign accept = bus.hsel & bus.hready & bus.htrans[1] & ready;
    assign region = decode_region(bus.haddr, CYCLE_EN);

    // A CTRL write still in its data phase has not reached run_reg yet;
    // forward it so a back-to-back IM/DM write sees the new run value.
    assign run_eff   = (csr_wr_reg && csr_off_reg == CSR_CTRL) ? bus.hwdata[0] : run_reg;
    assign mem_write = bus.hwrite && (region == R_IM || region == R_DM);
    assign illegal   = (region == R_ERR) || (bus.hsize != HSIZE_WORD) ||
                       (bus.hwrite && region == R_RF) || (mem_write && run_eff);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_RD_WAIT: state_next = S_IDLE;
            S_ERR1:    state_next = S_ERR2;
            default: begin
                state_next = S_IDLE;
                if (accept) begin
                    if (illegal) begin
                        state_next = S_ERR1;
                    end else if (!bus.hwrite && region != R_CSR) begin
                        state_next = S_RD_WAIT;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            im_wr_reg      <= 1'b0;
            dm_wr_reg      <= 1'b0;
            csr_wr_reg     <= 1'b0;
            csr_rd_reg     <= 1'b0;
            rd_done_reg    <= 1'b0;
            rd_region_reg  <= R_IM;
            csr_off_reg    <= '0;
            im_addr_reg    <= '0;
            dm_addr_reg    <= '0;
            rf_addr_reg    <= '0;
            run_reg        <= RST_RUN;
            wr_blocked_reg <= 1'b0;
        end else begin
            im_wr_reg   <= accept && !illegal && bus.hwrite && region == R_IM;
            dm_wr_reg   <= accept && !illegal && bus.hwrite && region == R_DM;
            csr_wr_reg  <= accept && !illegal && bus.hwrite && region == R_CSR;
            csr_rd_reg  <= accept && !illegal && !bus.hwrite && region == R_CSR;
            rd_done_reg <= (state_reg == S_RD_WAIT);
            if (accept) begin
                rd_region_reg <= region;
                csr_off_reg   <= bus.haddr[3:2];
            end
            if (accept && !illegal && region == R_IM) im_addr_reg <= bus.haddr[MEM_AW+1:2];
            if (accept && !illegal && region == R_DM) dm_addr_reg <= bus.haddr[MEM_AW+1:2];
            if (accept && !illegal && region == R_RF) rf_addr_reg <= bus.haddr[RF_AW+1:2];
            if (csr_wr_reg && csr_off_reg == CSR_CTRL) run_reg <= bus.hwdata[0];
            // Setting a new block wins over a simultaneous write-1-to-clear.
            if (accept && mem_write && run_eff) begin
                wr_blocked_reg <= 1'b1;
            end else if (csr_wr_reg && csr_off_reg == CSR_STATUS && bus.hwdata[0]) begin
                wr_blocked_reg <= 1'b0;
            end
        end
    end

`ifdef CPU_LOADER_CYCLE_EN
    cpu_cycle_counter u_cycle_counter (
        .clk        (clk),
        .rst        (rst),
        .enable     (run_reg),
        .load       (csr_wr_reg && csr_off_reg == CSR_CYCLE),
        .load_value (bus.hwdata),
        .count      (cycle_count)
    );
`else
    assign cycle_count = '0;
`endif

    // Memory read data is returned the cycle after RD_WAIT; CSR reads are
    // served from live registers in their data phase.
    always_comb begin
        rdata = '0;
        if (rd_done_reg) begin
            case (rd_region_reg)
                R_IM:    rdata = ahb_im_dout;
                R_DM:    rdata = ahb_dm_dout;
                R_RF:    rdata = ahb_rf_data;
                default: rdata = '0;
            endcase
        end else if (csr_rd_reg) begin
            case (csr_off_reg)
                CSR_CTRL:   rdata = {31'd0, run_reg};
                CSR_STATUS: rdata = {30'd0, run_reg, wr_blocked_reg};
                CSR_CYCLE:  rdata = cycle_count;
                default:    rdata = '0;
            endcase
        end
    end

    assign bus.hreadyout = ready;
    assign bus.hresp     = (state_reg == S_ERR1 || state_reg == S_ERR2);
    assign bus.hrdata    = rdata;
    assign cpu_rstn      = run_reg;

    // Write enables are masked by rst so a write caught by reset in its
    // data phase never reaches the memory.
    assign ahb_im_wen  = im_wr_reg & ~rst;
    assign ahb_dm_wen  = dm_wr_reg & ~rst;
    assign ahb_im_din  = im_wr_reg ? bus.hwdata : '0;
    assign ahb_dm_din  = dm_wr_reg ? bus.hwdata : '0;
    assign ahb_im_addr = im_addr_reg;
    assign ahb_dm_addr = dm_addr_reg;
    assign ahb_rf_addr = rf_addr_reg;
endmodule

// File: tb/tb_ahb_cpu_loader.sv
// tb_ahb_cpu_loader
// Directed bench for ahb_cpu_loader: synchronous IM/DM/RF models, host
// transfers driven on the falling edge, outputs checked 1 time unit later.
module tb_ahb_cpu_loader;
    import cpu_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_rstn;
    logic [10:0] ahb_im_addr, ahb_dm_addr;
    logic [31:0] ahb_im_din, ahb_dm_din, ahb_im_dout, ahb_dm_dout;
    logic        ahb_im_wen, ahb_dm_wen;
    logic [4:0]  ahb_rf_addr;
    logic [31:0] ahb_rf_data;

    logic [31:0] im_mem [0:2047];
    logic [31:0] dm_mem [0:2047];
    int          im_wen_cnt = 0;
    int          dm_wen_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    ahb_cpu_loader_if bus ();
    assign bus.hready = bus.hreadyout;

    ahb_cpu_loader #(.MEM_AW(11), .RF_AW(5), .RST_RUN(1'b0)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .cpu_rstn    (cpu_rstn),
        .ahb_im_addr (ahb_im_addr),
        .ahb_im_din  (ahb_im_din),
        .ahb_im_wen  (ahb_im_wen),
        .ahb_im_dout (ahb_im_dout),
        .ahb_dm_addr (ahb_dm_addr),
        .ahb_dm_din  (ahb_dm_din),
        .ahb_dm_wen  (ahb_dm_wen),
        .ahb_dm_dout (ahb_dm_dout),
        .ahb_rf_addr (ahb_rf_addr),
        .ahb_rf_data (ahb_rf_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ahb_im_wen) begin
            im_mem[ahb_im_addr] <= ahb_im_din;
            im_wen_cnt <= im_wen_cnt + 1;
        end
        if (ahb_dm_wen) begin
            dm_mem[ahb_dm_addr] <= ahb_dm_din;
            dm_wen_cnt <= dm_wen_cnt + 1;
        end
        ahb_im_dout <= im_mem[ahb_im_addr];
        ahb_dm_dout <= dm_mem[ahb_dm_addr];
        ahb_rf_data <= (ahb_rf_addr == 5'd2) ? 32'hDEADBEEF : {27'd0, ahb_rf_addr};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_drive(input logic sel, input logic [15:0] addr, input logic wr,
                             input logic [2:0] size, input logic [31:0] wdata);
        bus.hsel   = sel;
        bus.htrans = sel ? HTRANS_NONSEQ : HTRANS_IDLE;
        bus.haddr  = addr;
        bus.hwrite = wr;
        bus.hsize  = size;
        bus.hwdata = wdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus_drive(1'b0, 16'h0, 1'b0, HSIZE_WORD, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        check("rst_hreadyout", 32'(bus.hreadyout), 32'd1);
        check("rst_hresp", 32'(bus.hresp), 32'd0);
        check("rst_hrdata", bus.hrdata, 32'd0);
        check("rst_cpu_rstn", 32'(cpu_rstn), 32'd0);
        check("rst_wen", 32'(ahb_im_wen | ahb_dm_wen), 32'd0);
        check("rst_addr", 32'({ahb_im_addr, ahb_dm_addr, ahb_rf_addr}), 32'd0);
        check("rst_din", ahb_im_din | ahb_dm_din, 32'd0);
        @(negedge clk); rst = 1'b0;

        // IM write with run=0
        @(negedge clk); bus_drive(1'b1, 16'h0004, 1'b1, HSIZE_WORD, 32'h0);
        @(negedge clk); bus_drive(1'b0, 16'h0, 1'b0, HSIZE_WORD, 32'h20080005); #1;
        check("imw_wen", 32'(ahb_im_wen), 32'd1);
        check("imw_addr", 32'(ahb_im_addr), 32'd1);
        check("imw_din", ahb_im_din, 32'h20080005);
        check("imw_hresp", 32'(bus.hresp), 32'd0);
        check("imw_ready", 32'(bus.hreadyout), 32'd1);
        // IM read back
        @(negedge clk); bus_drive(1'b1, 16'h0004, 1'b0, HSIZE_WORD, 32'h0); #1;
        check("imw_wen_off", 32'(ahb_im_wen), 32'd0);
        check("imw_count", 32'(im_wen_cnt), 32'd1);
        @(negedge clk); bus_drive(1'b0, 16'h0, 1'b0, HSIZE_WORD, 32'h0); #1;
        check("imr_wait", 32'(bus.hreadyout), 32'd0);
        check("imr_addr", 32'(ahb_im_addr), 32'd1);
        @(negedge clk); #1;
        check("imr_ready", 32'(bus.hreadyout), 32'd1);
        check("imr_data", bus.hrdata, 32'h20080005);

        // CTRL=1 then DM write back-to-back: blocked
        @(negedge clk); bus_drive(1'b1, 16'h8000, 1'b1, HSIZE_WORD, 32'h0);
        @(negedge clk); bus_drive(1'b1, 16'h2000, 1'b1, HSIZE_WORD, 32'h1); #1;
        check("ctrl_dp_hresp", 32'(bus.hresp), 32'd0);
        check("ctrl_not_yet", 32'(cpu_rstn), 32'd0);
        @(negedge clk); bus_drive(1'b0, 16'h0, 1'b0, HSIZE_WORD, 32'h12345678); #1;
        check("blk_err1", {30'd0, bus.hresp, bus.hreadyout}, 32'h2);
        check("blk_wen1", 32'(ahb_dm_wen), 32'd0);
        check("ctrl_cpu_rstn", 32'(cpu_rstn), 32'd1);
        @(negedge clk); bus_drive(1'b1, 16'h8004, 1'b0, HSIZE_WORD, 32'h0); #1;
        check("blk_err2", {30'd0, bus.hresp, bus.hreadyout}, 32'h3);
        check("blk_wen2", 32'(ahb_dm_wen), 32'd0);
        @(negedge clk); bus_drive(1'b1, 16'h8004, 1'b1, HSIZE_WORD, 32'h0); #1;
        check("status_blocked", bus.hrdata, 32'h3);
        check("status_hresp", 32'(bus.hresp), 32'd0);
        @(negedge clk); bus_drive(1'b1, 16'h8004, 1'b0, HSIZE_WORD, 32'h1);
        @(negedge clk); bus_drive(1'b0, 16'h0, 1'b0, HSIZE_WORD, 32'h0); #1;
        check("status_cleared", bus.hrdata, 32'h2);
        check("blk_dm_count", 32'(dm_wen_cnt), 32'd0);

        // RF read
        @(negedge clk); bus_drive(1'b1, 16'h4008, 1'b0, HSIZE_WORD, 32'h0);
        @(negedge clk); bus_drive(1'b0, 16'h0, 1'b0, HSIZE_WORD, 32'h0); #1;
        check("rf_wait", 32'(bus.hreadyout), 32'd0);
        check("rf_addr", 32'(ahb_rf_addr), 32'd2);
        @(negedge clk); #1;
        check("rf_ready", 32'(bus.hreadyout), 32'd1);
        check("rf_data", bus.hrdata, 32'hDEADBEEF);

        // Illegal accesses: RF write, halfword DM read, just past RF
        @(negedge clk); bus_drive(1'b1, 16'h4000, 1'b1, HSIZE_WORD, 32'h0);
        @(negedge clk); bus_drive(1'b0, 16'h0, 1'b0, HSIZE_WORD, 32'h0); #1;
        check("rfw_err1", {30'd0, bus.hresp, bus.hreadyout}, 32'h2);
        @(negedge clk); #1;
        check("rfw_err2", {30'd0, bus.hresp, bus.hreadyout}, 32'h3);
        @(negedge clk); bus_drive(1'b1, 16'h2000, 1'b0, 3'b001, 32'h0);
        @(negedge clk); bus_drive(1'b0, 16'h0, 1'b0, HSIZE_WORD, 32'h0); #1;
        check("hsize_err", 32'(bus.hresp), 32'd1);
        @(negedge clk);
        @(negedge clk); bus_drive(1'b1, 16'h4080, 1'b0, HSIZE_WORD, 32'h0);
        @(negedge clk); bus_drive(1'b0, 16'h0, 1'b0, HSIZE_WORD, 32'h0); #1;
        check("unmapped_err", 32'(bus.hresp), 32'd1);
        @(negedge clk);

        // CTRL=0 then DM write back-to-back: allowed
        @(negedge clk); bus_drive(1'b1, 16'h8000, 1'b1, HSIZE_WORD, 32'h0);
        @(negedge clk); bus_drive(1'b1, 16'h2010, 1'b1, HSIZE_WORD, 32'h0);
        @(negedge clk); bus_drive(1'b0, 16'h0, 1'b0, HSIZE_WORD, 32'hCAFE0004); #1;
        check("dmw_wen", 32'(ahb_dm_wen), 32'd1);
        check("dmw_addr", 32'(ahb_dm_addr), 32'd4);
        check("dmw_hresp", 32'(bus.hresp), 32'd0);
        check("run_off", 32'(cpu_rstn), 32'd0);
        // read DM 0x2010, then write DM 0x2014 back-to-back
        @(negedge clk); bus_drive(1'b1, 16'h2010, 1'b0, HSIZE_WORD, 32'h0);
        @(negedge clk); bus_drive(1'b0, 16'h0, 1'b0, HSIZE_WORD, 32'h0); #1;
        check("b2b_wait", 32'(bus.hreadyout), 32'd0);
        check("b2b_rd_addr", 32'(ahb_dm_addr), 32'd4);
        @(negedge clk); bus_drive(1'b1, 16'h2014, 1'b1, HSIZE_WORD, 32'h0); #1;
        check("b2b_rd_data", bus.hrdata, 32'hCAFE0004);
        check("b2b_no_wen", 32'(ahb_dm_wen), 32'd0);
        @(negedge clk); bus_drive(1'b0, 16'h0, 1'b0, HSIZE_WORD, 32'h5); #1;
        check("b2b_wen", 32'(ahb_dm_wen), 32'd1);
        check("b2b_wr_addr", 32'(ahb_dm_addr), 32'd5);
        check("b2b_wr_din", ahb_dm_din, 32'h5);
        @(negedge clk); bus_drive(1'b0, 16'h0, 1'b0, HSIZE_WORD, 32'h0); #1;
        check("b2b_wen_off", 32'(ahb_dm_wen), 32'd0);
        check("dm_count", 32'(dm_wen_cnt), 32'd2);

`ifdef CPU_LOADER_CYCLE_EN
        // CYCLE=0xFFFFFFFE, run=1; the count reaches 1 three cycles after run rises
        @(negedge clk); bus_drive(1'b1, 16'h8008, 1'b1, HSIZE_WORD, 32'h0);
        @(negedge clk); bus_drive(1'b1, 16'h8000, 1'b1, HSIZE_WORD, 32'hFFFFFFFE);
        @(negedge clk); bus_drive(1'b0, 16'h0, 1'b0, HSIZE_WORD, 32'h1);
        @(negedge clk); bus_drive(1'b0, 16'h0, 1'b0, HSIZE_WORD, 32'h0);
        @(negedge clk);
        @(negedge clk); bus_drive(1'b1, 16'h8008, 1'b0, HSIZE_WORD, 32'h0);
        @(negedge clk); bus_drive(1'b0, 16'h0, 1'b0, HSIZE_WORD, 32'h0); #1;
        check("cycle_wrap", bus.hrdata, 32'h00000001);
        check("cycle_hresp", 32'(bus.hresp), 32'd0);
`else
        @(negedge clk); bus_drive(1'b1, 16'h8008, 1'b0, HSIZE_WORD, 32'h0);
        @(negedge clk); bus_drive(1'b0, 16'h0, 1'b0, HSIZE_WORD, 32'h0); #1;
        check("cycle_unmapped", 32'(bus.hresp), 32'd1);
        @(negedge clk);
`endif

        // Reset in the middle of a read
        @(negedge clk); bus_drive(1'b1, 16'h0004, 1'b0, HSIZE_WORD, 32'h0);
        @(negedge clk); bus_drive(1'b0, 16'h0, 1'b0, HSIZE_WORD, 32'h0); #1;
        check("mrd_wait", 32'(bus.hreadyout), 32'd0);
        rst = 1'b1;
        @(negedge clk); #1;
        check("mrd_ready", 32'(bus.hreadyout), 32'd1);
        check("mrd_hresp", 32'(bus.hresp), 32'd0);
        check("mrd_hrdata", bus.hrdata, 32'd0);
        check("mrd_cpu_rstn", 32'(cpu_rstn), 32'd0);
        rst = 1'b0;

        // Reset in the data phase of an IM write: no wen
        @(negedge clk); bus_drive(1'b1, 16'h0008, 1'b1, HSIZE_WORD, 32'h0);
        @(negedge clk); rst = 1'b1; bus_drive(1'b0, 16'h0, 1'b0, HSIZE_WORD, 32'hBAD0BAD0); #1;
        check("mwr_no_wen", 32'(ahb_im_wen), 32'd0);
        @(negedge clk); rst = 1'b0; #1;
        check("mwr_count", 32'(im_wen_cnt), 32'd1);
        check("mwr_ready", 32'(bus.hreadyout), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
